// File: rtl/axi_rd_arbiter.sv
// Purpose : round-robin share of one AXI4 read master (AR+R) among NREQ command requesters, one burst in flight.
// Latency : accept in cycle 0, arvalid in cycle 1, first R beat forwarded from cycle 2; next accept after the rlast handshake.
// Backpr. : AR held stable until arready; R is pass-through, so rready follows the granted requester's rsp_ready_in.
// Optional: define AXI_RD_ARB_TIMEOUT_EN to add an R-channel watchdog that ends a stalled burst with one SLVERR beat.
module axi_rd_arbiter #(
   parameter int NREQ       = 4,
   parameter int ADDRWIDTH  = 32,
   parameter int DATAWIDTH  = 32,
   parameter int TMO_CYCLES = 1024
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic [NREQ-1:0]           req_valid_in,
   output logic [NREQ-1:0]           req_ready_out,
   input  logic [NREQ*ADDRWIDTH-1:0] req_addr_in,
   input  logic [NREQ*8-1:0]         req_len_in,
   output logic [NREQ-1:0]           rsp_valid_out,
   input  logic [NREQ-1:0]           rsp_ready_in,
   output logic [DATAWIDTH-1:0]      rsp_data_out,
   output logic [1:0]                rsp_resp_out,
   output logic                      rsp_last_out,
   output logic [ADDRWIDTH-1:0]      m_axi_araddr_out,
   output logic [7:0]                m_axi_arlen_out,
   output logic [11:0]               m_axi_arid_out,
   output logic [1:0]                m_axi_arburst_out,
   output logic [2:0]                m_axi_arsize_out,
   output logic [3:0]                m_axi_arcache_out,
   output logic                      m_axi_arlock_out,
   output logic [2:0]                m_axi_arprot_out,
   output logic [3:0]                m_axi_arqos_out,
   output logic [3:0]                m_axi_arregion_out,
   output logic                      m_axi_arvalid_out,
   input  logic                      m_axi_arready_in,
   input  logic [DATAWIDTH-1:0]      m_axi_rdata_in,
   input  logic [11:0]               m_axi_rid_in,
   input  logic [1:0]                m_axi_rresp_in,
   input  logic                      m_axi_rlast_in,
   input  logic                      m_axi_rvalid_in,
   output logic                      m_axi_rready_out
);

   localparam int         GW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [2:0] ARSIZE = 3'($clog2(DATAWIDTH / 8));

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]           state;
   logic [GW-1:0]        rr_ptr;
   logic [GW-1:0]        grant;
   logic [GW-1:0]        sel_idx;
   logic                 sel_vld;
   logic [NREQ-1:0]      sel_oh;
   logic [NREQ-1:0]      gnt_oh;
   logic [GW-1:0]        next_ptr;
   logic                 arvalid_q;
   logic [ADDRWIDTH-1:0] araddr_q;
   logic [7:0]           arlen_q;
   logic                 r_hs;
   logic                 burst_done;
   logic                 tmo_pend;

   // rid is ignored: only one read is ever outstanding, so every beat belongs to the grant
   logic                 rid_unused;
   assign rid_unused = ^m_axi_rid_in;

   // AR sideband that never changes
   assign m_axi_arburst_out  = 2'b01;
   assign m_axi_arsize_out   = ARSIZE;
   assign m_axi_arcache_out  = 4'b0011;
   assign m_axi_arlock_out   = 1'b0;
   assign m_axi_arprot_out   = 3'b000;
   assign m_axi_arqos_out    = 4'b0000;
   assign m_axi_arregion_out = 4'b0000;

   assign m_axi_arvalid_out = arvalid_q;
   assign m_axi_araddr_out  = araddr_q;
   assign m_axi_arlen_out   = arlen_q;
   assign m_axi_arid_out    = 12'(grant);

   assign sel_oh   = NREQ'(1) << sel_idx;
   assign gnt_oh   = NREQ'(1) << grant;
   assign next_ptr = (grant == GW'(NREQ - 1)) ? '0 : grant + 1'b1;

   // Pick the first valid requester searching cyclically upward from rr_ptr
   always_comb begin
      logic [GW-1:0] idx;
      idx     = '0;
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = GW'((int'(rr_ptr) + k) % NREQ);
         if (!sel_vld && req_valid_in[idx]) begin
            sel_vld = 1'b1;
            sel_idx = idx;
         end
      end
   end

   // Accept pulse only while idle; also kept low while reset is asserted
   assign req_ready_out = (rst_n_in && (state == S_IDLE) && sel_vld) ? sel_oh : '0;

   // R channel steering: direct pass-through in DATA, or the synthetic error beat on watchdog expiry
   always_comb begin
      m_axi_rready_out = 1'b0;
      rsp_valid_out    = '0;
      rsp_data_out     = '0;
      rsp_resp_out     = 2'b00;
      rsp_last_out     = 1'b0;
      if (state == S_DATA) begin
         if (tmo_pend) begin
            rsp_valid_out = gnt_oh;
            rsp_resp_out  = 2'b10;
            rsp_last_out  = 1'b1;
         end else begin
            m_axi_rready_out = rsp_ready_in[grant];
            rsp_valid_out    = gnt_oh & {NREQ{m_axi_rvalid_in}};
            rsp_data_out     = m_axi_rdata_in;
            rsp_resp_out     = m_axi_rresp_in;
            rsp_last_out     = m_axi_rlast_in;
         end
      end
   end

   assign r_hs = m_axi_rvalid_in && m_axi_rready_out;

`ifdef AXI_RD_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   assign tmo_pend   = (tmo_cnt == 16'(TMO_CYCLES));
   assign burst_done = (r_hs && m_axi_rlast_in) || (tmo_pend && rsp_ready_in[grant]);

   // Watchdog counts DATA cycles without an R handshake; freezes once expired
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tmo_cnt <= '0;
      end else if ((state == S_ADDR) && m_axi_arready_in) begin
         tmo_cnt <= '0;
      end else if (state == S_DATA) begin
         if (r_hs) begin
            tmo_cnt <= '0;
         end else if (!tmo_pend) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end
      end
   end
`else
   // Watchdog compiled out: TMO_CYCLES is never negative, so this is a constant 0
   assign tmo_pend   = (TMO_CYCLES < 0);
   assign burst_done = r_hs && m_axi_rlast_in;
`endif

   // Control FSM: grant and capture command, present AR, wait for the end of the burst
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         grant     <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_vld) begin
                  grant     <= sel_idx;
                  araddr_q  <= req_addr_in[sel_idx*ADDRWIDTH +: ADDRWIDTH];
                  arlen_q   <= req_len_in[sel_idx*8 +: 8];
                  arvalid_q <= 1'b1;
                  state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (m_axi_arready_in) begin
                  arvalid_q <= 1'b0;
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               if (burst_done) begin
                  rr_ptr <= next_ptr;
                  state  <= S_IDLE;
               end
            end
            default: begin
               arvalid_q <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter (NREQ=4, 32-bit address/data, default build).
// Inputs driven 1 time unit after the rising edge, outputs checked on the falling edge.
module tb_axi_rd_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic [NREQ-1:0]   req_valid_in;
   logic [NREQ-1:0]   req_ready_out;
   logic [NREQ*AW-1:0] req_addr_in;
   logic [NREQ*8-1:0] req_len_in;
   logic [NREQ-1:0]   rsp_valid_out;
   logic [NREQ-1:0]   rsp_ready_in;
   logic [DW-1:0]     rsp_data_out;
   logic [1:0]        rsp_resp_out;
   logic              rsp_last_out;
   logic [AW-1:0]     m_axi_araddr_out;
   logic [7:0]        m_axi_arlen_out;
   logic [11:0]       m_axi_arid_out;
   logic [1:0]        m_axi_arburst_out;
   logic [2:0]        m_axi_arsize_out;
   logic [3:0]        m_axi_arcache_out;
   logic              m_axi_arlock_out;
   logic [2:0]        m_axi_arprot_out;
   logic [3:0]        m_axi_arqos_out;
   logic [3:0]        m_axi_arregion_out;
   logic              m_axi_arvalid_out;
   logic              m_axi_arready_in;
   logic [DW-1:0]     m_axi_rdata_in;
   logic [11:0]       m_axi_rid_in;
   logic [1:0]        m_axi_rresp_in;
   logic              m_axi_rlast_in;
   logic              m_axi_rvalid_in;
   logic              m_axi_rready_out;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   axi_rd_arbiter #(.NREQ(NREQ), .ADDRWIDTH(AW), .DATAWIDTH(DW), .TMO_CYCLES(16)) dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .req_valid_in       (req_valid_in),
      .req_ready_out      (req_ready_out),
      .req_addr_in        (req_addr_in),
      .req_len_in         (req_len_in),
      .rsp_valid_out      (rsp_valid_out),
      .rsp_ready_in       (rsp_ready_in),
      .rsp_data_out       (rsp_data_out),
      .rsp_resp_out       (rsp_resp_out),
      .rsp_last_out       (rsp_last_out),
      .m_axi_araddr_out   (m_axi_araddr_out),
      .m_axi_arlen_out    (m_axi_arlen_out),
      .m_axi_arid_out     (m_axi_arid_out),
      .m_axi_arburst_out  (m_axi_arburst_out),
      .m_axi_arsize_out   (m_axi_arsize_out),
      .m_axi_arcache_out  (m_axi_arcache_out),
      .m_axi_arlock_out   (m_axi_arlock_out),
      .m_axi_arprot_out   (m_axi_arprot_out),
      .m_axi_arqos_out    (m_axi_arqos_out),
      .m_axi_arregion_out (m_axi_arregion_out),
      .m_axi_arvalid_out  (m_axi_arvalid_out),
      .m_axi_arready_in   (m_axi_arready_in),
      .m_axi_rdata_in     (m_axi_rdata_in),
      .m_axi_rid_in       (m_axi_rid_in),
      .m_axi_rresp_in     (m_axi_rresp_in),
      .m_axi_rlast_in     (m_axi_rlast_in),
      .m_axi_rvalid_in    (m_axi_rvalid_in),
      .m_axi_rready_out   (m_axi_rready_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      tick();
      rst_n_in = 1'b1;
   endtask

   // One complete transaction with an always-ready slave and requester; err_beat < 0 means all OKAY
   task automatic run_burst(input logic [3:0] vmask, input int g, input logic [31:0] addr,
                            input logic [7:0] len, input int err_beat, input bit keep);
      logic [3:0]  oh;
      logic [31:0] d;
      oh = 4'b0001 << g;
      req_addr_in[g*AW +: AW] = addr;
      req_len_in[g*8 +: 8]    = len;
      req_valid_in     = vmask;
      m_axi_arready_in = 1'b1;
      rsp_ready_in     = 4'hF;
      m_axi_rvalid_in  = 1'b0;
      m_axi_rlast_in   = 1'b0;
      @(negedge clk_in);
      chk($sformatf("accept_g%0d", g), req_ready_out, oh);
      chk("idle_rsp_valid", rsp_valid_out, 4'h0);
      chk("idle_rready", m_axi_rready_out, 1'b0);
      chk("idle_arvalid", m_axi_arvalid_out, 1'b0);
      tick();
      if (!keep) req_valid_in = 4'h0;
      @(negedge clk_in);
      chk("arvalid", m_axi_arvalid_out, 1'b1);
      chk("araddr", m_axi_araddr_out, addr);
      chk("arlen", m_axi_arlen_out, len);
      chk("arid", m_axi_arid_out, 12'(g));
      chk("addr_no_accept", req_ready_out, 4'h0);
      tick();
      for (int b = 0; b <= int'(len); b++) begin
         d = 32'hD000_0000 | 32'(g << 8) | 32'(b);
         m_axi_rvalid_in = 1'b1;
         m_axi_rdata_in  = d;
         m_axi_rid_in    = 12'(g);
         m_axi_rresp_in  = (b == err_beat) ? 2'b10 : 2'b00;
         m_axi_rlast_in  = (b == int'(len));
         @(negedge clk_in);
         chk($sformatf("beat%0d_valid", b), rsp_valid_out, oh);
         chk($sformatf("beat%0d_rready", b), m_axi_rready_out, 1'b1);
         chk($sformatf("beat%0d_data", b), rsp_data_out, d);
         chk($sformatf("beat%0d_resp", b), rsp_resp_out, (b == err_beat) ? 2'b10 : 2'b00);
         chk($sformatf("beat%0d_last", b), rsp_last_out, (b == int'(len)));
         chk($sformatf("beat%0d_arvalid", b), m_axi_arvalid_out, 1'b0);
         tick();
      end
      m_axi_rvalid_in = 1'b0;
      m_axi_rlast_in  = 1'b0;
      m_axi_rresp_in  = 2'b00;
      m_axi_rdata_in  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int  exp_g [5];
      int  k;
      bit  tog;
      exp_g = '{0, 1, 2, 3, 0};

      rst_n_in         = 1'b0;
      req_valid_in     = '0;
      req_addr_in      = '0;
      req_len_in       = '0;
      rsp_ready_in     = '0;
      m_axi_arready_in = 1'b0;
      m_axi_rdata_in   = '0;
      m_axi_rid_in     = '0;
      m_axi_rresp_in   = '0;
      m_axi_rlast_in   = 1'b0;
      m_axi_rvalid_in  = 1'b0;

      // Reset state and constant AR sideband
      tick();
      @(negedge clk_in);
      chk("rst_req_ready", req_ready_out, 4'h0);
      chk("rst_rsp_valid", rsp_valid_out, 4'h0);
      chk("rst_arvalid", m_axi_arvalid_out, 1'b0);
      chk("rst_rready", m_axi_rready_out, 1'b0);
      chk("rst_araddr", m_axi_araddr_out, 32'h0);
      chk("rst_arlen", m_axi_arlen_out, 8'h0);
      chk("rst_arid", m_axi_arid_out, 12'h0);
      chk("arburst", m_axi_arburst_out, 2'b01);
      chk("arsize", m_axi_arsize_out, 3'd2);
      chk("arcache", m_axi_arcache_out, 4'b0011);
      chk("arlock", m_axi_arlock_out, 1'b0);
      chk("arprot", m_axi_arprot_out, 3'd0);
      chk("arqos", m_axi_arqos_out, 4'd0);
      chk("arregion", m_axi_arregion_out, 4'd0);
      tick();
      rst_n_in = 1'b1;

      // Single request, 4-beat burst
      run_burst(4'b0001, 0, 32'h1000_0000, 8'd3, -1, 1'b0);
      @(negedge clk_in);
      chk("t1_idle_ready", req_ready_out, 4'h0);
      chk("t1_idle_arvalid", m_axi_arvalid_out, 1'b0);
      chk("t1_idle_rsp_valid", rsp_valid_out, 4'h0);
      tick();

      // All requesters valid continuously: round robin 0,1,2,3,0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_burst(4'hF, exp_g[i], 32'h2000_0000 + 32'(exp_g[i] * 256), 8'd0, -1, 1'b1);
      end
      req_valid_in = 4'h0;

      // Backpressure: arready low 5 cycles, rsp_ready_in[2] toggling (pointer now 1, only req2 asks)
      req_addr_in[2*AW +: AW] = 32'h3000_0040;
      req_len_in[2*8 +: 8]    = 8'd2;
      req_valid_in     = 4'b0100;
      m_axi_arready_in = 1'b0;
      @(negedge clk_in);
      chk("bp_accept", req_ready_out, 4'b0100);
      tick();
      req_valid_in = 4'h0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_in);
         chk($sformatf("bp_arvalid_c%0d", c), m_axi_arvalid_out, 1'b1);
         chk($sformatf("bp_araddr_c%0d", c), m_axi_araddr_out, 32'h3000_0040);
         chk($sformatf("bp_arid_c%0d", c), m_axi_arid_out, 12'd2);
         tick();
      end
      m_axi_arready_in = 1'b1;
      @(negedge clk_in);
      chk("bp_arvalid_c5", m_axi_arvalid_out, 1'b1);
      chk("bp_araddr_c5", m_axi_araddr_out, 32'h3000_0040);
      tick();
      m_axi_arready_in = 1'b0;
      k   = 0;
      tog = 1'b0;
      for (int c = 0; c < 12 && k < 3; c++) begin
         rsp_ready_in    = {1'b1, tog, 2'b11};
         m_axi_rvalid_in = 1'b1;
         m_axi_rdata_in  = 32'h0000_00B0 + 32'(k);
         m_axi_rresp_in  = 2'b00;
         m_axi_rlast_in  = (k == 2);
         @(negedge clk_in);
         chk($sformatf("bp_rready_c%0d", c), m_axi_rready_out, tog);
         chk($sformatf("bp_valid_c%0d", c), rsp_valid_out, 4'b0100);
         chk($sformatf("bp_data_c%0d", c), rsp_data_out, 32'h0000_00B0 + 32'(k));
         chk($sformatf("bp_last_c%0d", c), rsp_last_out, (k == 2));
         tick();
         if (tog) k++;
         tog = ~tog;
      end
      m_axi_rvalid_in = 1'b0;
      m_axi_rlast_in  = 1'b0;
      rsp_ready_in    = 4'hF;
      @(negedge clk_in);
      chk("bp_done_valid", rsp_valid_out, 4'h0);
      chk("bp_done_rready", m_axi_rready_out, 1'b0);
      tick();

      // SLVERR on beat 2 of 3 passes through for that beat only (pointer 3, only req1 asks)
      run_burst(4'b0010, 1, 32'h4000_0100, 8'd2, 1, 1'b0);

      // Reset in the middle of a burst (pointer 2, only req0 asks)
      req_addr_in[0 +: AW] = 32'h5000_0000;
      req_len_in[0 +: 8]   = 8'd3;
      req_valid_in     = 4'b0001;
      m_axi_arready_in = 1'b1;
      rsp_ready_in     = 4'hF;
      @(negedge clk_in);
      chk("mr_accept", req_ready_out, 4'b0001);
      tick();
      req_valid_in = 4'h0;
      @(negedge clk_in);
      chk("mr_arvalid", m_axi_arvalid_out, 1'b1);
      tick();
      m_axi_rvalid_in = 1'b1;
      m_axi_rdata_in  = 32'h0000_00C0;
      @(negedge clk_in);
      chk("mr_beat1", rsp_valid_out, 4'b0001);
      tick();
      m_axi_rdata_in = 32'h0000_00C1;
      @(negedge clk_in);
      chk("mr_beat2", rsp_valid_out, 4'b0001);
      #1 rst_n_in = 1'b0;
      #1;
      chk("mr_rst_req_ready", req_ready_out, 4'h0);
      chk("mr_rst_rsp_valid", rsp_valid_out, 4'h0);
      chk("mr_rst_rready", m_axi_rready_out, 1'b0);
      chk("mr_rst_arvalid", m_axi_arvalid_out, 1'b0);
      chk("mr_rst_araddr", m_axi_araddr_out, 32'h0);
      chk("mr_rst_arlen", m_axi_arlen_out, 8'h0);
      chk("mr_rst_arid", m_axi_arid_out, 12'h0);
      m_axi_rvalid_in = 1'b0;
      m_axi_rdata_in  = '0;
      tick();
      tick();
      rst_n_in = 1'b1;
      // Pointer must be back at 0: with req1 and req3 asking, req1 wins
      run_burst(4'b1010, 1, 32'h6000_0100, 8'd0, -1, 1'b0);
      run_burst(4'b1000, 3, 32'h6000_0300, 8'd1, -1, 1'b0);
      @(negedge clk_in);
      chk("end_idle_valid", rsp_valid_out, 4'h0);
      chk("end_idle_arvalid", m_axi_arvalid_out, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
